// File: rtl/tr_bus_master.sv
// tr_bus_master: FIFO-buffered master that arbitrates with req/gnt and drives bufif0 data/enable flops.
// Optional even-parity output bus_par is added when TR_BUS_PARITY_EN is defined.
module tr_bus_master #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 4,
  parameter int TURN_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [DATA_W-1:0] bus_dout,
  output logic              data_enable_low,
`ifdef TR_BUS_PARITY_EN
  output logic              bus_par,
`endif
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  typedef enum logic [1:0] {IDLE, REQ, DRIVE, TURN} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [BW-1:0]     r_beats;
  logic [TW-1:0]     r_turn;
  logic              r_req, r_del;
  logic [DATA_W-1:0] r_dout;
  logic              w_full, w_empty, w_push, w_pop;
  logic [DATA_W-1:0] w_head;
  assign w_full          = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_empty         = r_count == '0;
  assign w_push          = in_valid && !w_full;
  // every pop lands in bus_dout on the same edge, so each driven cycle carries one fresh word
  assign w_pop           = bus_gnt && !w_empty &&
                           (r_state == REQ || (r_state == DRIVE && r_beats < BW'(MAX_BURST)));
  assign w_head          = r_mem[r_rd_ptr];
  assign in_ready        = !w_full;
  assign busy            = r_state != IDLE || !w_empty;
  assign bus_req         = r_req;
  assign bus_dout        = r_dout;
  assign data_enable_low = r_del;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_del   <= 1'b1;
      r_dout  <= '0;
      r_beats <= '0;
      r_turn  <= '0;
    end else begin
      case (r_state)
        IDLE: if (!w_empty) begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end
        REQ: if (w_pop) begin
          r_state <= DRIVE;
          r_del   <= 1'b0;
          r_dout  <= w_head;
          r_beats <= BW'(1);
        end
        DRIVE: if (w_pop) begin
          r_dout  <= w_head;
          r_beats <= r_beats + 1'b1;
        end else begin
          r_state <= TURN;
          r_del   <= 1'b1;
          r_req   <= 1'b0;
          r_turn  <= '0;
        end
        TURN: if (r_turn == TW'(TURN_CYC - 1)) r_state <= IDLE;
              else r_turn <= r_turn + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
`ifdef TR_BUS_PARITY_EN
  logic r_par;
  assign bus_par = r_par;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_par <= 1'b0;
    else if (w_pop) r_par <= ^w_head;
`endif
endmodule

// File: tb/tb_tr_bus_master.sv
// tb_tr_bus_master: directed + randomized bench; a word-queue scoreboard and burst/gap rules form the reference.
`timescale 1ns/1ps
module tb_tr_bus_master;
  localparam int DATA_W = 8, DEPTH = 4, MAXB = 4, TURN = 1;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, bus_gnt = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_ready, bus_req, data_enable_low, busy;
  logic [DATA_W-1:0] bus_dout;
`ifdef TR_BUS_PARITY_EN
  logic bus_par;
`endif
  int n_chk = 0, n_pass = 0;
  logic [DATA_W-1:0] q[$];
  int bursts[$];
  int pushes, beats, cur_len, gap, n, w;
  bit prev_drv, seen_burst, acc, gnt_set;
  logic [DATA_W-1:0] last_dout;

  tr_bus_master #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB), .TURN_CYC(TURN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_dout(bus_dout),
    .data_enable_low(data_enable_low),
`ifdef TR_BUS_PARITY_EN
    .bus_par(bus_par),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    bursts.delete();
    pushes = 0; beats = 0; cur_len = 0; gap = 0;
    prev_drv = 0; seen_burst = 0; last_dout = '0;
  endtask

  // one clock: record an accepted push, then check the bus against the scoreboard
  task automatic step(output bit accepted);
    logic [DATA_W-1:0] e;
    accepted = in_valid && in_ready;
    if (accepted) begin q.push_back(in_data); pushes++; end
    @(posedge clk); #1;
    if (!data_enable_low) begin
      if (q.size() > 0) e = q.pop_front(); else e = 'x;
      chk("beat_data", bus_dout, e);
      chk("req_while_drive", bus_req, 1);
`ifdef TR_BUS_PARITY_EN
      chk("par_drive", bus_par, ^e);
`endif
      beats++;
      if (prev_drv) begin cur_len++; chk("burst_len", cur_len <= MAXB, 1); end
      else begin
        if (seen_burst) chk("turn_gap", gap >= TURN + 2, 1);
        cur_len = 1;
      end
      last_dout = bus_dout;
    end else begin
      if (prev_drv) begin bursts.push_back(cur_len); seen_burst = 1; gap = 1; end
      else gap++;
      chk("dout_hold", bus_dout, last_dout);
`ifdef TR_BUS_PARITY_EN
      chk("par_hold", bus_par, ^last_dout);
`endif
      if (seen_burst && gap <= TURN + 1) chk("req_low_turn", bus_req, 0);
    end
    prev_drv = !data_enable_low;
    chk("in_ready", in_ready, (pushes - beats) < DEPTH);
    if (pushes != beats) chk("busy_pending", busy, 1);
  endtask

  task automatic push_words(input int first, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      in_valid = 1; in_data = DATA_W'(first + k);
      step(acc);
      chk("push_accept", acc, 1);
    end
    in_valid = 0;
  endtask

  initial begin
    model_reset();
    // reset
    #12;
    chk("rst_del", data_enable_low, 1); chk("rst_req", bus_req, 0); chk("rst_dout", bus_dout, 0);
    chk("rst_ready", in_ready, 1); chk("rst_busy", busy, 0);
    #10 rst_n = 1;
    repeat (4) begin
      step(acc);
      chk("idle_del", data_enable_low, 1); chk("idle_req", bus_req, 0); chk("idle_busy", busy, 0);
    end
    // single word with grant tied high
    bus_gnt = 1;
    in_valid = 1; in_data = 8'hA5;
    step(acc); in_valid = 0;
    chk("a5_accept", acc, 1);
    step(acc); chk("a5_req_e1", bus_req, 1); chk("a5_del_e1", data_enable_low, 1);
    step(acc); chk("a5_del_e2", data_enable_low, 0); chk("a5_dout_e2", bus_dout, 8'hA5);
    step(acc); chk("a5_del_e3", data_enable_low, 1); chk("a5_req_e3", bus_req, 0); chk("a5_busy_e3", busy, 1);
    step(acc); chk("a5_busy_e4", busy, 0);
    // six words, FIFO fills while grant is withheld
    bursts.delete();
    bus_gnt = 0; w = 1; n = 0; gnt_set = 0;
    while (w <= 6 && n < 100) begin
      in_valid = 1; in_data = DATA_W'(w);
      step(acc);
      if (acc) w++;
      n++;
      if (w == 5 && !gnt_set) begin chk("full_ready", in_ready, 0); bus_gnt = 1; gnt_set = 1; end
    end
    in_valid = 0;
    chk("six_all_pushed", w, 7);
    repeat (20) step(acc);
    chk("six_nbursts", bursts.size(), 2);
    if (bursts.size() == 2) begin chk("six_b0", bursts[0], 4); chk("six_b1", bursts[1], 2); end
    chk("six_q_empty", q.size(), 0);
    // grant withdrawn after the second beat
    bursts.delete();
    bus_gnt = 0;
    push_words(8'h11, 4);
    bus_gnt = 1; n = 0;
    while (!(!data_enable_low && cur_len == 2) && n < 50) begin step(acc); n++; end
    chk("drop_at_beat2", cur_len, 2);
    bus_gnt = 0;
    repeat (3) step(acc);
    bus_gnt = 1;
    repeat (15) step(acc);
    chk("drop_nbursts", bursts.size(), 2);
    if (bursts.size() == 2) begin chk("drop_b0", bursts[0], 2); chk("drop_b1", bursts[1], 2); end
    chk("drop_q_empty", q.size(), 0);
    // asynchronous reset in the middle of a burst
    push_words(8'h21, 3);
    n = 0;
    while (data_enable_low && n < 20) begin step(acc); n++; end
    chk("mid_driving", data_enable_low, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_del", data_enable_low, 1); chk("arst_req", bus_req, 0); chk("arst_dout", bus_dout, 0);
    chk("arst_busy", busy, 0); chk("arst_ready", in_ready, 1);
    model_reset();
    #1 rst_n = 1;
    repeat (3) begin step(acc); chk("post_rst_busy", busy, 0); chk("post_rst_del", data_enable_low, 1); end
`ifdef TR_BUS_PARITY_EN
    push_words(8'h07, 1);
    n = 0;
    while (data_enable_low && n < 20) begin step(acc); n++; end
    chk("par_07", bus_par, 1);
    repeat (4) step(acc);
    push_words(8'h03, 1);
    n = 0;
    while (data_enable_low && n < 20) begin step(acc); n++; end
    chk("par_03", bus_par, 0);
    repeat (4) step(acc);
`endif
    // randomized traffic with a flaky grant
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DATA_W'($urandom);
      bus_gnt  = $urandom_range(0, 3) != 0;
      step(acc);
    end
    in_valid = 0; bus_gnt = 1; n = 0;
    while ((q.size() > 0 || busy) && n < 200) begin step(acc); n++; end
    chk("drain_q_empty", q.size(), 0);
    chk("drain_busy", busy, 0);
    chk("drain_balance", pushes, beats);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
